block_map: RTL and testbench
============================

// Module: block_map
// PURPOSE
// - Brick-field store answering the bm_* request interface driven by the game state controller.
// - Holds a ROWS x COLS grid of 4-bit block codes.
// - Serves four requests: read a cell, hit a cell, load a stage pattern, clear the field.
// - Second read-only port feeds the VGA renderer; a live count of breakable blocks feeds win detection.
// PARAMETERS
// - ROWS  16  grid rows (1..32)
// - COLS  10  grid columns (1..32); N = ROWS*COLS cells, row-major index = row*COLS+col
// PORTS
// - clock         in   1  system clock, single clock domain
// - reset         in   1  asynchronous, active-low reset
// - bm_enable     in   1  request strobe; accepted when bm_enable && bm_ready
// - bm_func       in   2  00 READ, 01 LOAD, 10 HIT, 11 CLEAR
// - bm_stage      in   2  stage pattern select (LOAD only)
// - bm_row        in   5  cell row (READ/HIT)
// - bm_col        in   5  cell column (READ/HIT)
// - bm_ready      out  1  idle, can accept a request
// - bm_block      out  4  READ: cell code; HIT: code before the hit
// - bm_done       out  1  one-cycle pulse, request complete
// - bm_remaining  out  10 number of cells holding code 1..14
// - v_row         in   5  renderer cell row
// - v_col         in   5  renderer cell column
// - v_block       out  4  renderer cell code
// BEHAVIOUR
// - Codes:
//   - 0 empty.
//   - 1..7 single-hit: HIT -> 0.
//   - 8..14 two-hit: HIT -> code-7.
//   - 15 indestructible: HIT leaves it unchanged.
// - Reset (async assert) values:
//   - All cells 0; bm_ready=1, bm_block=0, bm_done=0, bm_remaining=0, v_block=0.
//   - FSM returns to IDLE; sweep index is 0.
// - FSM states:
//   - IDLE: bm_ready=1. Accept at cycle T.
//     - READ/HIT: complete in one cycle; the FSM stays in IDLE.
//     - LOAD/CLEAR: go to SWEEP.
//   - SWEEP: bm_ready=0; idx runs 0..N-1 and writes one cell per cycle.
//     - LOAD writes pattern(bm_stage latched at T, row, col); CLEAR writes 0.
//     - After idx==N-1 the FSM returns to IDLE.
// - Latency:
//   - READ/HIT: bm_block and bm_done valid at T+1; bm_ready stays 1; back-to-back requests allowed.
//   - HIT write-back is visible to a READ accepted at T+1.
//   - LOAD/CLEAR: bm_ready=0 for cycles T+1..T+N; bm_done=1 and bm_ready=1 at T+N+1.
// - bm_block holds its value until the next READ/HIT completes. LOAD/CLEAR leave it unchanged.
// - bm_remaining:
//   - LOAD/CLEAR: zeroed at T+1. LOAD then adds 1 for each cell written with code 1..14.
//   - HIT: decrements at T+1 only when the old code is 1..7.
// - Out of range (row>=ROWS or col>=COLS):
//   - READ returns 0.
//   - HIT returns 0 and writes nothing.
//   - v_block returns 0.
// - bm_enable while bm_ready=0 is ignored: no queueing and no side effect.
// - bm_func is sampled only on acceptance; input changes during SWEEP have no effect.
// - v_block is registered: it is the code at (v_row,v_col) one cycle after sampling.
//   - If a write hits the same cell in the same cycle, v_block shows the pre-write value.
// - Reset asserted mid-SWEEP: the grid is fully cleared immediately and no bm_done is issued.
// - Stage patterns:
//   - 0: rows 0..3 = 1, all other rows 0.
//   - 1: rows 0..5, (row+col) even = 9, odd = 0.
//   - 2: rows 0..7 = (row%7)+1; row 0 also has col 0 and col COLS-1 = 15.
//   - 3: rows 0..7 = ((row+col)%14)+1.
// STRUCTURE
// - Shared package holds:
//   - BM_READ/BM_LOAD/BM_HIT/BM_CLEAR func codes.
//   - BLK_EMPTY=0, BLK_SOLID=15, BLK_HARD_MIN=8.
//   - hit_next(code) and is_breakable(code) functions.
// - Sub-module stage_pattern: combinational (stage,row,col) -> code ROM used by the LOAD sweep.
// - Grid is a flop array: async clear is required, so no inferred RAM.
// TESTING
// - Reset release, LOAD stage 0 at T:
//   - bm_ready=0 for 160 cycles; bm_done and bm_ready high at T+161; bm_remaining=40.
//   - READ(0,5) -> 1; READ(4,5) -> 0.
// - After stage 1 load, HIT(0,0): old=9 -> bm_block=9, cell becomes 2, bm_remaining unchanged.
//   - Second HIT(0,0) -> bm_block=2, cell 0, bm_remaining decrements by 1.
// - Stage 2 load, HIT(0,0) -> bm_block=15, cell stays 15, bm_remaining unchanged. HIT(20,3) -> 0, no write.
// - READ/HIT request with bm_enable held during SWEEP is ignored.
//   - CLEAR then gives bm_remaining=0 and every v_block read = 0.
// - Assert reset at sweep idx 50 of a LOAD:
//   - Outputs go to reset values immediately; bm_done is never pulsed.
//   - First request after release is accepted.
// - HIT(2,3) at T with v_row=2, v_col=3 held: v_block shows the old code at T+1 and the new code at T+2.

Source files
------------

// File: rtl/block_map_pkg.sv
// Shared definitions for the brick-field store: request codes, block codes
// and the per-hit block transition helpers.
package block_map_pkg;

    localparam logic [1:0] BM_READ  = 2'b00;
    localparam logic [1:0] BM_LOAD  = 2'b01;
    localparam logic [1:0] BM_HIT   = 2'b10;
    localparam logic [1:0] BM_CLEAR = 2'b11;

    localparam logic [3:0] BLK_EMPTY    = 4'd0;
    localparam logic [3:0] BLK_SOLID    = 4'd15;
    localparam logic [3:0] BLK_HARD_MIN = 4'd8;
    localparam logic [3:0] BLK_HIT_STEP = 4'd7;

    // Code a cell takes after being hit once.
    function automatic logic [3:0] hit_next(input logic [3:0] code);
        logic [3:0] next_code;
        if (code == BLK_SOLID) begin
            next_code = code;
        end else if (code >= BLK_HARD_MIN) begin
            next_code = code - BLK_HIT_STEP;
        end else begin
            next_code = BLK_EMPTY;
        end
        return next_code;
    endfunction

    function automatic logic is_breakable(input logic [3:0] code);
        return (code != BLK_EMPTY) && (code != BLK_SOLID);
    endfunction

    function automatic logic is_single_hit(input logic [3:0] code);
        return (code != BLK_EMPTY) && (code < BLK_HARD_MIN);
    endfunction

endpackage

// File: rtl/block_map_stage_pattern.sv
// Combinational stage layout ROM: (stage,row,col) -> block code used while
// the LOAD sweep fills the grid.
module stage_pattern
    import block_map_pkg::*;
#(
    parameter int COLS = 10
) (
    input  logic [1:0] stage,
    input  logic [4:0] row,
    input  logic [4:0] col,
    output logic [3:0] code
);

    localparam logic [4:0] LAST_COL = 5'(COLS - 1);

    logic [5:0] sum_s;
    logic [5:0] mod14_s;

    // Pattern lookup per stage; rows outside each stage's band stay empty.
    always_comb begin
        code    = BLK_EMPTY;
        sum_s   = {1'b0, row} + {1'b0, col};
        if (sum_s >= 6'd28) begin
            mod14_s = sum_s - 6'd28;
        end else if (sum_s >= 6'd14) begin
            mod14_s = sum_s - 6'd14;
        end else begin
            mod14_s = sum_s;
        end
        case (stage)
            2'd0: begin
                if (row < 5'd4) code = 4'd1;
                else            code = BLK_EMPTY;
            end
            2'd1: begin
                if (row < 5'd6 && !sum_s[0]) code = 4'd9;
                else                         code = BLK_EMPTY;
            end
            2'd2: begin
                if (row == 5'd0 && (col == 5'd0 || col == LAST_COL)) code = BLK_SOLID;
                else if (row == 5'd7)                                 code = 4'd1;
                else if (row < 5'd7)                                  code = row[3:0] + 4'd1;
                else                                                  code = BLK_EMPTY;
            end
            2'd3: begin
                if (row < 5'd8) code = mod14_s[3:0] + 4'd1;
                else            code = BLK_EMPTY;
            end
            default: code = BLK_EMPTY;
        endcase
    end

endmodule

// File: rtl/block_map.sv
// Brick-field store: ROWS x COLS grid of 4-bit block codes with a request
// port (read/hit/load/clear), a renderer read port and a breakable count.
module block_map
    import block_map_pkg::*;
#(
    parameter int ROWS = 16,
    parameter int COLS = 10
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       bm_enable,
    input  logic [1:0] bm_func,
    input  logic [1:0] bm_stage,
    input  logic [4:0] bm_row,
    input  logic [4:0] bm_col,
    output logic       bm_ready,
    output logic [3:0] bm_block,
    output logic       bm_done,
    output logic [9:0] bm_remaining,
    input  logic [4:0] v_row,
    input  logic [4:0] v_col,
    output logic [3:0] v_block
);

    localparam int         N        = ROWS * COLS;
    localparam logic [9:0] LAST_IDX = 10'(N - 1);
    localparam logic [9:0] COLS_V   = 10'(COLS);
    localparam logic [5:0] ROWS_LIM = 6'(ROWS);
    localparam logic [5:0] COLS_LIM = 6'(COLS);
    localparam logic [4:0] LAST_COL = 5'(COLS - 1);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_SWEEP = 1'b1;

    logic [3:0] grid_r [N];
    logic [0:0] state_r;
    logic [9:0] idx_r;
    logic [4:0] sw_row_r;
    logic [4:0] sw_col_r;
    logic       sweep_load_r;
    logic [1:0] stage_r;
    logic       ready_r;
    logic [3:0] block_r;
    logic       done_r;
    logic [9:0] remaining_r;
    logic [3:0] v_block_r;

    logic       accept_s;
    logic       req_in_range_s;
    logic       v_in_range_s;
    logic [9:0] req_idx_s;
    logic [9:0] v_idx_s;
    logic [3:0] req_cell_s;
    logic [3:0] v_cell_s;
    logic [3:0] req_val_s;
    logic [3:0] pat_code_s;
    logic [3:0] sweep_data_s;
    logic       wr_en_s;
    logic [9:0] wr_idx_s;
    logic [3:0] wr_data_s;

    stage_pattern #(.COLS(COLS)) u_stage_pattern (
        .stage (stage_r),
        .row   (sw_row_r),
        .col   (sw_col_r),
        .code  (pat_code_s)
    );

    // Address decode and read muxes for both ports.
    always_comb begin
        accept_s       = bm_enable && ready_r && (state_r == ST_IDLE);
        req_in_range_s = ({1'b0, bm_row} < ROWS_LIM) && ({1'b0, bm_col} < COLS_LIM);
        v_in_range_s   = ({1'b0, v_row} < ROWS_LIM) && ({1'b0, v_col} < COLS_LIM);
        req_idx_s      = {5'd0, bm_row} * COLS_V + {5'd0, bm_col};
        v_idx_s        = {5'd0, v_row} * COLS_V + {5'd0, v_col};
        req_cell_s     = BLK_EMPTY;
        v_cell_s       = BLK_EMPTY;
        for (int i = 0; i < N; i++) begin
            req_cell_s = (req_idx_s == 10'(i)) ? grid_r[i] : req_cell_s;
            v_cell_s   = (v_idx_s == 10'(i)) ? grid_r[i] : v_cell_s;
        end
        req_val_s    = req_in_range_s ? req_cell_s : BLK_EMPTY;
        sweep_data_s = sweep_load_r ? pat_code_s : BLK_EMPTY;
    end

    // Single grid write port: the sweep owns it, otherwise an in-range HIT.
    always_comb begin
        wr_en_s   = 1'b0;
        wr_idx_s  = 10'd0;
        wr_data_s = BLK_EMPTY;
        if (state_r == ST_SWEEP) begin
            wr_en_s   = 1'b1;
            wr_idx_s  = idx_r;
            wr_data_s = sweep_data_s;
        end else if (accept_s && bm_func == BM_HIT && req_in_range_s) begin
            wr_en_s   = 1'b1;
            wr_idx_s  = req_idx_s;
            wr_data_s = hit_next(req_cell_s);
        end else begin
            wr_en_s   = 1'b0;
        end
    end

    // Grid storage; kept in flops so reset can clear it at once.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < N; i++) grid_r[i] <= BLK_EMPTY;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (wr_en_s && wr_idx_s == 10'(i)) grid_r[i] <= wr_data_s;
            end
        end
    end

    // Request FSM, sweep counters and registered outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r      <= ST_IDLE;
            idx_r        <= 10'd0;
            sw_row_r     <= 5'd0;
            sw_col_r     <= 5'd0;
            sweep_load_r <= 1'b0;
            stage_r      <= 2'd0;
            ready_r      <= 1'b1;
            block_r      <= BLK_EMPTY;
            done_r       <= 1'b0;
            remaining_r  <= 10'd0;
            v_block_r    <= BLK_EMPTY;
        end else begin
            done_r    <= 1'b0;
            v_block_r <= v_in_range_s ? v_cell_s : BLK_EMPTY;
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        case (bm_func)
                            BM_READ: begin
                                block_r <= req_val_s;
                                done_r  <= 1'b1;
                            end
                            BM_HIT: begin
                                block_r <= req_val_s;
                                done_r  <= 1'b1;
                                if (req_in_range_s && is_single_hit(req_cell_s))
                                    remaining_r <= remaining_r - 10'd1;
                            end
                            default: begin
                                state_r      <= ST_SWEEP;
                                ready_r      <= 1'b0;
                                idx_r        <= 10'd0;
                                sw_row_r     <= 5'd0;
                                sw_col_r     <= 5'd0;
                                sweep_load_r <= (bm_func == BM_LOAD);
                                stage_r      <= bm_stage;
                                remaining_r  <= 10'd0;
                            end
                        endcase
                    end
                end
                ST_SWEEP: begin
                    if (is_breakable(sweep_data_s)) remaining_r <= remaining_r + 10'd1;
                    if (idx_r == LAST_IDX) begin
                        state_r <= ST_IDLE;
                        ready_r <= 1'b1;
                        done_r  <= 1'b1;
                        idx_r   <= 10'd0;
                    end else begin
                        idx_r <= idx_r + 10'd1;
                        if (sw_col_r == LAST_COL) begin
                            sw_col_r <= 5'd0;
                            sw_row_r <= sw_row_r + 5'd1;
                        end else begin
                            sw_col_r <= sw_col_r + 5'd1;
                        end
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    ready_r <= 1'b1;
                end
            endcase
        end
    end

    assign bm_ready     = ready_r;
    assign bm_block     = block_r;
    assign bm_done      = done_r;
    assign bm_remaining = remaining_r;
    assign v_block      = v_block_r;

endmodule

// File: tb/tb_block_map.sv
// Directed bench for block_map: each task drives one scenario and checks
// hand-computed values on the falling clock edge.
module tb_block_map;
    import block_map_pkg::*;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       bm_enable = 1'b0;
    logic [1:0] bm_func = 2'd0;
    logic [1:0] bm_stage = 2'd0;
    logic [4:0] bm_row = 5'd0;
    logic [4:0] bm_col = 5'd0;
    logic       bm_ready;
    logic [3:0] bm_block;
    logic       bm_done;
    logic [9:0] bm_remaining;
    logic [4:0] v_row = 5'd0;
    logic [4:0] v_col = 5'd0;
    logic [3:0] v_block;

    int vectors = 0;
    int miscompares = 0;

    block_map #(.ROWS(16), .COLS(10)) dut (
        .clock(clock), .reset(reset), .bm_enable(bm_enable), .bm_func(bm_func),
        .bm_stage(bm_stage), .bm_row(bm_row), .bm_col(bm_col), .bm_ready(bm_ready),
        .bm_block(bm_block), .bm_done(bm_done), .bm_remaining(bm_remaining),
        .v_row(v_row), .v_col(v_col), .v_block(v_block)
    );

    always #5 clock = ~clock;

    // Present a request for one cycle; returns at the falling edge of T+1.
    task automatic do_req(input logic [1:0] f, input logic [1:0] s, input logic [4:0] r, input logic [4:0] c);
        bm_enable = 1'b1; bm_func = f; bm_stage = s; bm_row = r; bm_col = c;
        @(negedge clock);
        bm_enable = 1'b0;
    endtask

    // Count busy cycles until bm_ready returns (bounded); notes any early done.
    task automatic sweep_wait(output int cycles, output bit early_done);
        cycles = 0; early_done = 1'b0;
        while (bm_ready !== 1'b1 && cycles < 400) begin
            if (bm_done !== 1'b0) early_done = 1'b1;
            cycles++;
            @(negedge clock);
        end
    endtask

    task automatic test_reset;
        repeat (2) @(negedge clock);
        vectors++; if (bm_ready !== 1'b1) begin miscompares++; $display("FAIL reset_ready got=%0d want=1", bm_ready); end
        vectors++; if (bm_block !== 4'd0) begin miscompares++; $display("FAIL reset_block got=%0d want=0", bm_block); end
        vectors++; if (bm_done !== 1'b0) begin miscompares++; $display("FAIL reset_done got=%0d want=0", bm_done); end
        vectors++; if (bm_remaining !== 10'd0) begin miscompares++; $display("FAIL reset_remaining got=%0d want=0", bm_remaining); end
        vectors++; if (v_block !== 4'd0) begin miscompares++; $display("FAIL reset_vblock got=%0d want=0", v_block); end
        reset = 1'b1;
        @(negedge clock);
    endtask

    task automatic test_load_stage0;
        int cyc; bit early;
        do_req(BM_LOAD, 2'd0, 5'd0, 5'd0);
        vectors++; if (bm_ready !== 1'b0) begin miscompares++; $display("FAIL load0_busy got=%0d want=0", bm_ready); end
        sweep_wait(cyc, early);
        vectors++; if (cyc != 160) begin miscompares++; $display("FAIL load0_busy_cycles got=%0d want=160", cyc); end
        vectors++; if (early) begin miscompares++; $display("FAIL load0_early_done got=1 want=0"); end
        vectors++; if (bm_done !== 1'b1) begin miscompares++; $display("FAIL load0_done got=%0d want=1", bm_done); end
        vectors++; if (bm_remaining !== 10'd40) begin miscompares++; $display("FAIL load0_remaining got=%0d want=40", bm_remaining); end
        @(negedge clock);
        vectors++; if (bm_done !== 1'b0) begin miscompares++; $display("FAIL load0_done_pulse got=%0d want=0", bm_done); end
        do_req(BM_READ, 2'd0, 5'd0, 5'd5);
        vectors++; if (bm_block !== 4'd1 || bm_done !== 1'b1) begin miscompares++; $display("FAIL read_0_5 got=%0d/%0d want=1/1", bm_block, bm_done); end
        do_req(BM_READ, 2'd0, 5'd4, 5'd5);
        vectors++; if (bm_block !== 4'd0) begin miscompares++; $display("FAIL read_4_5 got=%0d want=0", bm_block); end
        do_req(BM_READ, 2'd0, 5'd3, 5'd9);
        vectors++; if (bm_block !== 4'd1) begin miscompares++; $display("FAIL read_3_9 got=%0d want=1", bm_block); end
    endtask

    task automatic test_hit_two_hit;
        int cyc; bit early;
        do_req(BM_LOAD, 2'd1, 5'd0, 5'd0);
        sweep_wait(cyc, early);
        vectors++; if (bm_remaining !== 10'd30) begin miscompares++; $display("FAIL load1_remaining got=%0d want=30", bm_remaining); end
        vectors++; if (bm_block !== 4'd1) begin miscompares++; $display("FAIL load_keeps_block got=%0d want=1", bm_block); end
        do_req(BM_READ, 2'd0, 5'd1, 5'd1);
        vectors++; if (bm_block !== 4'd9) begin miscompares++; $display("FAIL s1_read_1_1 got=%0d want=9", bm_block); end
        do_req(BM_READ, 2'd0, 5'd1, 5'd0);
        vectors++; if (bm_block !== 4'd0) begin miscompares++; $display("FAIL s1_read_1_0 got=%0d want=0", bm_block); end
        do_req(BM_HIT, 2'd0, 5'd0, 5'd0);
        vectors++; if (bm_block !== 4'd9 || bm_remaining !== 10'd30) begin miscompares++; $display("FAIL hit1 got=%0d/%0d want=9/30", bm_block, bm_remaining); end
        do_req(BM_READ, 2'd0, 5'd0, 5'd0);
        vectors++; if (bm_block !== 4'd2) begin miscompares++; $display("FAIL hit1_cell got=%0d want=2", bm_block); end
        do_req(BM_HIT, 2'd0, 5'd0, 5'd0);
        vectors++; if (bm_block !== 4'd2 || bm_remaining !== 10'd29) begin miscompares++; $display("FAIL hit2 got=%0d/%0d want=2/29", bm_block, bm_remaining); end
        do_req(BM_READ, 2'd0, 5'd0, 5'd0);
        vectors++; if (bm_block !== 4'd0) begin miscompares++; $display("FAIL hit2_cell got=%0d want=0", bm_block); end
    endtask

    task automatic test_solid_and_range;
        int cyc; bit early;
        do_req(BM_LOAD, 2'd2, 5'd0, 5'd0);
        vectors++; if (bm_remaining !== 10'd0) begin miscompares++; $display("FAIL load2_zeroed got=%0d want=0", bm_remaining); end
        sweep_wait(cyc, early);
        vectors++; if (bm_remaining !== 10'd78) begin miscompares++; $display("FAIL load2_remaining got=%0d want=78", bm_remaining); end
        do_req(BM_HIT, 2'd0, 5'd0, 5'd0);
        vectors++; if (bm_block !== 4'd15 || bm_remaining !== 10'd78) begin miscompares++; $display("FAIL hit_solid got=%0d/%0d want=15/78", bm_block, bm_remaining); end
        do_req(BM_READ, 2'd0, 5'd0, 5'd0);
        vectors++; if (bm_block !== 4'd15) begin miscompares++; $display("FAIL solid_stays got=%0d want=15", bm_block); end
        do_req(BM_READ, 2'd0, 5'd0, 5'd9);
        vectors++; if (bm_block !== 4'd15) begin miscompares++; $display("FAIL s2_read_0_9 got=%0d want=15", bm_block); end
        do_req(BM_READ, 2'd0, 5'd7, 5'd4);
        vectors++; if (bm_block !== 4'd1) begin miscompares++; $display("FAIL s2_read_7_4 got=%0d want=1", bm_block); end
        do_req(BM_READ, 2'd0, 5'd3, 5'd4);
        vectors++; if (bm_block !== 4'd4) begin miscompares++; $display("FAIL s2_read_3_4 got=%0d want=4", bm_block); end
        do_req(BM_HIT, 2'd0, 5'd20, 5'd3);
        vectors++; if (bm_block !== 4'd0 || bm_done !== 1'b1 || bm_remaining !== 10'd78) begin miscompares++; $display("FAIL hit_oob got=%0d/%0d/%0d want=0/1/78", bm_block, bm_done, bm_remaining); end
        do_req(BM_READ, 2'd0, 5'd0, 5'd10);
        vectors++; if (bm_block !== 4'd0) begin miscompares++; $display("FAIL read_oob_col got=%0d want=0", bm_block); end
    endtask

    task automatic test_back_to_back;
        do_req(BM_HIT, 2'd0, 5'd1, 5'd2);
        vectors++; if (bm_block !== 4'd2 || bm_done !== 1'b1 || bm_ready !== 1'b1) begin miscompares++; $display("FAIL b2b_hit got=%0d/%0d/%0d want=2/1/1", bm_block, bm_done, bm_ready); end
        do_req(BM_READ, 2'd0, 5'd1, 5'd2);
        vectors++; if (bm_block !== 4'd0 || bm_done !== 1'b1 || bm_remaining !== 10'd77) begin miscompares++; $display("FAIL b2b_read got=%0d/%0d/%0d want=0/1/77", bm_block, bm_done, bm_remaining); end
    endtask

    task automatic test_vblock;
        v_row = 5'd2; v_col = 5'd3;
        @(negedge clock);
        vectors++; if (v_block !== 4'd3) begin miscompares++; $display("FAIL vblock_pre got=%0d want=3", v_block); end
        do_req(BM_HIT, 2'd0, 5'd2, 5'd3);
        vectors++; if (v_block !== 4'd3 || bm_block !== 4'd3) begin miscompares++; $display("FAIL vblock_t1 got=%0d/%0d want=3/3", v_block, bm_block); end
        @(negedge clock);
        vectors++; if (v_block !== 4'd0 || bm_remaining !== 10'd76) begin miscompares++; $display("FAIL vblock_t2 got=%0d/%0d want=0/76", v_block, bm_remaining); end
        v_row = 5'd0; v_col = 5'd9;
        @(negedge clock);
        vectors++; if (v_block !== 4'd15) begin miscompares++; $display("FAIL vblock_0_9 got=%0d want=15", v_block); end
        v_row = 5'd16; v_col = 5'd0;
        @(negedge clock);
        vectors++; if (v_block !== 4'd0) begin miscompares++; $display("FAIL vblock_oob got=%0d want=0", v_block); end
    endtask

    task automatic test_sweep_ignore_and_clear;
        int cyc; bit early;
        int bad;
        bm_enable = 1'b1; bm_func = BM_LOAD; bm_stage = 2'd3; bm_row = 5'd0; bm_col = 5'd0;
        @(negedge clock);
        bm_func = BM_HIT; bm_stage = 2'd0;
        vectors++; if (bm_remaining !== 10'd0) begin miscompares++; $display("FAIL load3_zeroed got=%0d want=0", bm_remaining); end
        sweep_wait(cyc, early);
        bm_enable = 1'b0;
        vectors++; if (cyc != 160 || early) begin miscompares++; $display("FAIL held_enable_busy got=%0d/%0d want=160/0", cyc, early); end
        vectors++; if (bm_remaining !== 10'd80) begin miscompares++; $display("FAIL load3_remaining got=%0d want=80", bm_remaining); end
        do_req(BM_READ, 2'd0, 5'd0, 5'd0);
        vectors++; if (bm_block !== 4'd1) begin miscompares++; $display("FAIL ignored_hit got=%0d want=1", bm_block); end
        do_req(BM_READ, 2'd0, 5'd7, 5'd9);
        vectors++; if (bm_block !== 4'd3) begin miscompares++; $display("FAIL s3_read_7_9 got=%0d want=3", bm_block); end
        do_req(BM_CLEAR, 2'd0, 5'd0, 5'd0);
        vectors++; if (bm_remaining !== 10'd0 || bm_ready !== 1'b0) begin miscompares++; $display("FAIL clear_t1 got=%0d/%0d want=0/0", bm_remaining, bm_ready); end
        sweep_wait(cyc, early);
        vectors++; if (cyc != 160 || bm_done !== 1'b1 || bm_remaining !== 10'd0) begin miscompares++; $display("FAIL clear_done got=%0d/%0d/%0d want=160/1/0", cyc, bm_done, bm_remaining); end
        vectors++; if (bm_block !== 4'd3) begin miscompares++; $display("FAIL clear_keeps_block got=%0d want=3", bm_block); end
        bad = 0;
        for (int r = 0; r < 16; r++) begin
            for (int c = 0; c < 10; c++) begin
                v_row = 5'(r); v_col = 5'(c);
                @(negedge clock);
                if (v_block !== 4'd0) bad++;
            end
        end
        vectors++; if (bad != 0) begin miscompares++; $display("FAIL clear_vblock_scan got=%0d nonzero want=0", bad); end
    endtask

    task automatic test_reset_midsweep;
        int seen_done;
        do_req(BM_LOAD, 2'd0, 5'd0, 5'd0);
        repeat (50) @(negedge clock);
        #1 reset = 1'b0;
        #1;
        vectors++; if (bm_ready !== 1'b1 || bm_done !== 1'b0 || bm_remaining !== 10'd0 || bm_block !== 4'd0 || v_block !== 4'd0)
            begin miscompares++; $display("FAIL midsweep_reset got=%0d/%0d/%0d/%0d/%0d want=1/0/0/0/0", bm_ready, bm_done, bm_remaining, bm_block, v_block); end
        seen_done = 0;
        repeat (3) begin @(negedge clock); if (bm_done !== 1'b0) seen_done++; end
        reset = 1'b1;
        repeat (200) begin @(negedge clock); if (bm_done !== 1'b0) seen_done++; end
        vectors++; if (seen_done != 0) begin miscompares++; $display("FAIL midsweep_no_done got=%0d want=0", seen_done); end
        do_req(BM_READ, 2'd0, 5'd0, 5'd5);
        vectors++; if (bm_done !== 1'b1 || bm_block !== 4'd0 || bm_remaining !== 10'd0) begin miscompares++; $display("FAIL after_reset_read got=%0d/%0d/%0d want=1/0/0", bm_done, bm_block, bm_remaining); end
    endtask

    initial begin
        test_reset();
        test_load_stage0();
        test_hit_two_hit();
        test_solid_and_range();
        test_back_to_back();
        test_vblock();
        test_sweep_ignore_and_clear();
        test_reset_midsweep();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
